update_position_pipe: RTL and testbench
=======================================

Name: update_position_pipe

Overview:
- Next-generation GbSB position integrator: x_next = x + dt*y, in signed fixed point with round-to-nearest and saturation.
- Optional inelastic-wall mode (ballistic/discrete SB): |x| > 1 clamps x to ±1 and zeroes y.
- Time-multiplexed: a frame of N oscillators streams through LANES parallel units over N/LANES beats.
- Sits between the momentum-update stage and the state memory, with valid/ready on both sides so the integrator loop can stall.

Parameters:
- N, 8, oscillators per frame; N % LANES == 0 required.
- LANES, 2, oscillators processed per beat.
- DATA_WIDTH, 32, signed two's-complement word width.
- FRAC_WIDTH, 16, fractional bits; ONE = 1 << FRAC_WIDTH.
- Derived: BEATS = N/LANES; IDX_W = max(1, clog2(BEATS)); HIT_W = clog2(N+1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_x  in  LANES*DATA_WIDTH  positions; lane k at bits [k*DW +: DW].
- in_y  in  LANES*DATA_WIDTH  momenta, same packing.
- dt  in  DATA_WIDTH  time step (signed Q); sampled on beat 0 only.
- wall_en  in  1  wall mode; sampled on beat 0 only.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the output beat.
- out_x  out  LANES*DATA_WIDTH  updated positions.
- out_y  out  LANES*DATA_WIDTH  momenta (passed through, or zeroed by a wall hit).
- out_idx  out  IDX_W  beat index of the output beat within its frame.
- out_last  out  1  high on beat BEATS-1.
- out_sat  out  LANES  per-lane saturation flag for this beat.
- hits  out  HIT_W  wall-hit total of the last completed frame.
- hits_valid  out  1  one-cycle pulse when hits updates.

Behaviour:
- Reset: out_valid=0, hits_valid=0, hits=0, out_x=0, out_y=0, out_idx=0, out_last=0, out_sat=0, all pipeline valids=0, input and output beat counters=0, running hit count=0, latched dt/wall_en=0.
- Pipeline:
  - 2 stages: S1 = multiply/round; S2 = add/saturate/wall, registered onto the outputs.
  - en = !out_valid || out_ready; in_ready = en. When en=0 every stage holds.
  - Outputs stay stable while out_valid && !out_ready.
  - Latency: 2 cycles from acceptance to out_valid with no backpressure; throughput 1 beat/cycle.
- Frame sequencing:
  - Input beat counter increments on each accept and wraps from BEATS-1 to 0.
  - On accept with counter==0, dt and wall_en are latched and used for the whole frame; changes mid-frame are ignored.
  - out_idx and out_last travel with the data.
- Arithmetic, per lane, signed:
  - p = dt * y, full 2*DW product.
  - pr = (p + (1 << (FRAC_WIDTH-1))) >>> FRAC_WIDTH (round half up).
  - s = x + pr, computed in DW+2 bits.
  - If s > 2^(DW-1)-1, saturate to 0x7FF..F; if s < -2^(DW-1), saturate to 0x800..0. out_sat[k]=1 on either saturation.
  - Product overflow beyond DW+1 bits also saturates by sign.
- Wall (latched wall_en=1):
  - s_sat > ONE gives x=ONE, y=0, hit.
  - s_sat < -ONE gives x=-ONE, y=0, hit.
  - |s_sat| == ONE is not a hit.
  - wall_en=0 gives x=s_sat, y=in_y unchanged.
- Hit counting:
  - The running count adds the number of hit lanes of each output beat when that beat is transferred (out_valid && out_ready).
  - On transfer of the out_last beat: hits = running count including that beat, hits_valid=1 for one cycle, running count cleared.
- Boundaries:
  - in_valid with in_ready=0: nothing accepted, counters unchanged.
  - Simultaneous output transfer and new input accept: both happen, no bubble.
  - rst mid-frame: partial frame discarded, no hits_valid; the next accepted beat is beat 0.
  - BEATS=1: every beat is last; out_idx is 0.

Test Plan (DW=32, FRAC=16, ONE=0x00010000):
- Wall hit and disable: dt=0x8000, y=0x00020000, x=0x4000, wall_en=1 -> out_x=0x00010000, out_y=0, lane counted as hit; same with wall_en=0 -> out_x=0x00014000, out_y=0x00020000, 2 cycles after accept.
- Negative wall: dt=0x8000, x=0xFFFFC000, y=0xFFFE0000, wall_en=1 -> out_x=0xFFFF0000, out_y=0; x=0xFFFF8000, y=0xFFFF0000 -> s=-ONE exactly, not a hit, y unchanged.
- Saturation and rounding: x=y=0x7FFF0000, dt=0x00010000 -> out_x=0x7FFFFFFF, out_sat=1. dt=1, y=0x8000, x=0 -> out_x=1 (half rounds up); y=0x7FFF -> out_x=0.
- Frame sequencing: N=8, LANES=2, 4 beats, dt changed after beat 0 -> all beats use the beat-0 dt; out_idx 0..3; out_last on beat 3; 3 wall hits in the frame -> hits=3 with a one-cycle hits_valid on the last transfer.
- Backpressure: out_ready low for 3 cycles mid-stream -> out_x, out_y and out_idx held, in_ready=0, no beats lost or duplicated; continuous 8-beat stream with out_ready=1 -> 1 beat/cycle.
- Reset mid-frame: assert rst after beat 2 accepted -> all outputs 0 next cycle, no hits_valid; the next beat is treated as beat 0 (out_idx=0, dt re-latched).

Source files
------------

// File: rtl/update_position_pipe.sv
// Two-stage position integrator x' = x + dt*y in signed fixed point (round half up, saturating)
// with an optional inelastic wall; LANES oscillators per beat, BEATS beats per frame.
module update_position_pipe #(
  parameter int N          = 8,
  parameter int LANES      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int FRAC_WIDTH = 16,
  localparam int BEATS     = N / LANES,
  localparam int IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int HIT_W     = $clog2(N + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_x,
  input  logic [LANES*DATA_WIDTH-1:0] in_y,
  input  logic [DATA_WIDTH-1:0]       dt,
  input  logic                        wall_en,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_x,
  output logic [LANES*DATA_WIDTH-1:0] out_y,
  output logic [IDX_W-1:0]            out_idx,
  output logic                        out_last,
  output logic [LANES-1:0]            out_sat,
  output logic [HIT_W-1:0]            hits,
  output logic                        hits_valid
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = 2 * DW;
  localparam int SW = DW + 2;
  localparam int TW = DW + 1;

  localparam logic signed [PW-1:0] HALF_P    = {{(PW-FRAC_WIDTH){1'b0}}, 1'b1, {(FRAC_WIDTH-1){1'b0}}};
  localparam logic signed [SW-1:0] S_MAX     = {3'b000, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] S_MIN     = {3'b111, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] W_MAX     = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] W_MIN     = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [DW-1:0] ONE_W     = {{(DW-FRAC_WIDTH-1){1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};
  localparam logic signed [DW-1:0] NEG_ONE_W = {{(DW-FRAC_WIDTH){1'b1}}, {FRAC_WIDTH{1'b0}}};
  localparam logic [IDX_W-1:0]     IDX_ZERO  = IDX_W'(32'd0);
  localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(BEATS - 1);

  // dt*y rounded back to Q format; anything wider than DW+1 bits clamps by sign
  function automatic logic signed [TW-1:0] scaled_step(input logic signed [DW-1:0] dt_v,
                                                       input logic signed [DW-1:0] y_v);
    logic signed [PW-1:0] prod_v;
    logic signed [PW-1:0] rnd_v;
    logic signed [TW-1:0] res_v;
    prod_v = $signed({{DW{dt_v[DW-1]}}, dt_v}) * $signed({{DW{y_v[DW-1]}}, y_v});
    rnd_v  = (prod_v + HALF_P) >>> FRAC_WIDTH;
    if ((&rnd_v[PW-1:DW]) || !(|rnd_v[PW-1:DW])) begin
      res_v = rnd_v[DW:0];
    end else if (rnd_v[PW-1]) begin
      res_v = {1'b1, {DW{1'b0}}};
    end else begin
      res_v = {1'b0, {DW{1'b1}}};
    end
    return res_v;
  endfunction

  // Returns {sat, hit, position} for one lane
  function automatic logic [DW+1:0] settle(input logic signed [DW-1:0] x_v,
                                           input logic signed [TW-1:0] step_v,
                                           input logic wall_v);
    logic signed [SW-1:0] sum_v;
    logic signed [DW-1:0] pos_v;
    logic sat_v;
    logic hit_v;
    sum_v = $signed({{2{x_v[DW-1]}}, x_v}) + $signed({step_v[DW], step_v});
    sat_v = 1'b0;
    hit_v = 1'b0;
    if (sum_v > S_MAX) begin
      pos_v = W_MAX;
      sat_v = 1'b1;
    end else if (sum_v < S_MIN) begin
      pos_v = W_MIN;
      sat_v = 1'b1;
    end else begin
      pos_v = sum_v[DW-1:0];
    end
    if (wall_v && (pos_v > ONE_W)) begin
      pos_v = ONE_W;
      hit_v = 1'b1;
    end else if (wall_v && (pos_v < NEG_ONE_W)) begin
      pos_v = NEG_ONE_W;
      hit_v = 1'b1;
    end else begin
      hit_v = 1'b0;
    end
    return {sat_v, hit_v, pos_v};
  endfunction

  function automatic logic [HIT_W-1:0] count_hits(input logic [LANES-1:0] h_v);
    logic [HIT_W-1:0] c_v;
    c_v = {HIT_W{1'b0}};
    for (int i = 0; i < LANES; i++) begin
      c_v = c_v + HIT_W'(h_v[i]);
    end
    return c_v;
  endfunction

  logic                   en_s;
  logic                   frame_start_s;
  logic [DW-1:0]          dt_use_s;
  logic                   wall_use_s;
  logic [LANES*TW-1:0]    step_s;
  logic [LANES*DW-1:0]    nx_x_s;
  logic [LANES*DW-1:0]    nx_y_s;
  logic [LANES-1:0]       nx_sat_s;
  logic [LANES-1:0]       nx_hit_s;
  logic [DW+1:0]          lane_res_s [LANES];
  logic [HIT_W-1:0]       beat_hits_s;

  logic [IDX_W-1:0]       in_cnt_r;
  logic [DW-1:0]          dt_r;
  logic                   wall_r;
  logic                   s1_valid_r;
  logic [LANES*DW-1:0]    s1_x_r;
  logic [LANES*DW-1:0]    s1_y_r;
  logic [LANES*TW-1:0]    s1_step_r;
  logic [IDX_W-1:0]       s1_idx_r;
  logic                   s1_last_r;
  logic                   s1_wall_r;
  logic [LANES-1:0]       out_hit_r;
  logic [HIT_W-1:0]       run_r;

  assign en_s        = !out_valid || out_ready;
  assign in_ready    = en_s;
  assign beat_hits_s = count_hits(out_hit_r);

  // Stage 1 inputs: beat 0 uses the live dt/wall_en, later beats the latched copy
  always_comb begin
    frame_start_s = (in_cnt_r == IDX_ZERO);
    dt_use_s      = frame_start_s ? dt : dt_r;
    wall_use_s    = frame_start_s ? wall_en : wall_r;
    step_s        = {(LANES*TW){1'b0}};
    for (int k = 0; k < LANES; k++) begin
      step_s[k*TW +: TW] = scaled_step(dt_use_s, in_y[k*DW +: DW]);
    end
  end

  // Stage 2: add, saturate and apply the wall to each lane
  always_comb begin
    nx_x_s   = {(LANES*DW){1'b0}};
    nx_y_s   = {(LANES*DW){1'b0}};
    nx_sat_s = {LANES{1'b0}};
    nx_hit_s = {LANES{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      lane_res_s[k]      = settle(s1_x_r[k*DW +: DW], s1_step_r[k*TW +: TW], s1_wall_r);
      nx_x_s[k*DW +: DW] = lane_res_s[k][DW-1:0];
      nx_hit_s[k]        = lane_res_s[k][DW];
      nx_sat_s[k]        = lane_res_s[k][DW+1];
      nx_y_s[k*DW +: DW] = lane_res_s[k][DW] ? {DW{1'b0}} : s1_y_r[k*DW +: DW];
    end
  end

  // Pipeline registers, frame sequencing and per-frame hit accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      in_cnt_r   <= IDX_ZERO;
      dt_r       <= {DW{1'b0}};
      wall_r     <= 1'b0;
      s1_valid_r <= 1'b0;
      s1_x_r     <= {(LANES*DW){1'b0}};
      s1_y_r     <= {(LANES*DW){1'b0}};
      s1_step_r  <= {(LANES*TW){1'b0}};
      s1_idx_r   <= IDX_ZERO;
      s1_last_r  <= 1'b0;
      s1_wall_r  <= 1'b0;
      out_valid  <= 1'b0;
      out_x      <= {(LANES*DW){1'b0}};
      out_y      <= {(LANES*DW){1'b0}};
      out_idx    <= IDX_ZERO;
      out_last   <= 1'b0;
      out_sat    <= {LANES{1'b0}};
      out_hit_r  <= {LANES{1'b0}};
      run_r      <= {HIT_W{1'b0}};
      hits       <= {HIT_W{1'b0}};
      hits_valid <= 1'b0;
    end else begin
      if (in_valid && en_s) begin
        in_cnt_r <= (in_cnt_r == LAST_IDX) ? IDX_ZERO : in_cnt_r + IDX_ONE;
        if (frame_start_s) begin
          dt_r   <= dt;
          wall_r <= wall_en;
        end
      end
      if (en_s) begin
        s1_valid_r <= in_valid;
        s1_x_r     <= in_x;
        s1_y_r     <= in_y;
        s1_step_r  <= step_s;
        s1_idx_r   <= in_cnt_r;
        s1_last_r  <= (in_cnt_r == LAST_IDX);
        s1_wall_r  <= wall_use_s;
        out_valid  <= s1_valid_r;
        out_x      <= nx_x_s;
        out_y      <= nx_y_s;
        out_idx    <= s1_idx_r;
        out_last   <= s1_last_r;
        out_sat    <= nx_sat_s;
        out_hit_r  <= nx_hit_s;
      end
      if (out_valid && out_ready && out_last) begin
        hits       <= run_r + beat_hits_s;
        run_r      <= {HIT_W{1'b0}};
        hits_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        run_r      <= run_r + beat_hits_s;
        hits_valid <= 1'b0;
      end else begin
        hits_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_update_position_pipe.sv
// Self-checking bench: directed test-plan frames plus randomized traffic and backpressure,
// scored against an exact 64-bit arithmetic model of the integrator.
module tb_update_position_pipe;

  localparam int BEATS = 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;
  localparam longint ONE  = 64'sd65536;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_x = 64'd0;
  logic [63:0] in_y = 64'd0;
  logic [31:0] dt = 32'd0;
  logic        wall_en = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_x;
  logic [63:0] out_y;
  logic [1:0]  out_idx;
  logic        out_last;
  logic [1:0]  out_sat;
  logic [3:0]  hits;
  logic        hits_valid;

  update_position_pipe #(.N(8), .LANES(2), .DATA_WIDTH(32), .FRAC_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .dt(dt), .wall_en(wall_en), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_y(out_y), .out_idx(out_idx), .out_last(out_last), .out_sat(out_sat), .hits(hits),
    .hits_valid(hits_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic [1:0]  sat;
    logic [1:0]  idx;
    logic        last;
    int          nhit;
  } beat_t;

  beat_t exp_q[$];
  beat_t log_q[$];
  int    hits_log[$];
  int    total = 0;
  int    passed = 0;
  int    rdy_mode = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Exact arithmetic: 64-bit product, round half up, then saturate and wall
  function automatic void model_lane(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] dtv, input logic wall,
                                     output logic [31:0] ox, output logic [31:0] oy,
                                     output logic sat, output logic hit);
    longint p, pr, s;
    p  = longint'($signed(dtv)) * longint'($signed(y));
    pr = (p + 64'sd32768) >>> 16;
    s  = longint'($signed(x)) + pr;
    sat = 1'b0; hit = 1'b0; oy = y;
    if (s > SMAX) begin s = SMAX; sat = 1'b1; end
    else if (s < SMIN) begin s = SMIN; sat = 1'b1; end
    if (wall && s > ONE) begin s = ONE; oy = 32'd0; hit = 1'b1; end
    else if (wall && s < -ONE) begin s = -ONE; oy = 32'd0; hit = 1'b1; end
    ox = s[31:0];
  endfunction

  int          m_cnt = 0;
  logic [31:0] m_dt = 32'd0;
  logic        m_wall = 1'b0;
  int          run = 0;
  bit          hv_pend = 1'b0;
  int          hits_exp = 0;
  bit          held = 1'b0;
  logic [129:0] held_v;

  // Compare process: model accepts, scoreboard transfers, hold stability and hit pulses
  always @(negedge clk) begin : mon
    beat_t e;
    beat_t a;
    logic [31:0] ox, oy;
    logic sat, hit;
    if (hv_pend) begin
      chk("hits_valid", hits_valid, 1'b1);
      chk("hits", hits, hits_exp);
      hits_log.push_back(int'(hits));
    end else begin
      chk("hits_valid_idle", hits_valid, 1'b0);
    end
    hv_pend = 1'b0;
    if (held) chk("hold", {out_x, out_y, out_idx}, held_v);
    held = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_cnt = 0;
      run = 0;
    end else begin
      chk("in_ready", in_ready, !out_valid || out_ready);
      if (out_valid && !out_ready) begin
        held = 1'b1;
        held_v = {out_x, out_y, out_idx};
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL unexpected_beat: got out_valid=1 idx=%0d expected no pending beat", out_idx);
        end else begin
          e = exp_q.pop_front();
          chk("beat", {out_x, out_y, out_sat, out_idx, out_last}, {e.x, e.y, e.sat, e.idx, e.last});
          a.x = out_x; a.y = out_y; a.sat = out_sat; a.idx = out_idx; a.last = out_last; a.nhit = 0;
          log_q.push_back(a);
          run += e.nhit;
          if (e.last) begin
            hv_pend = 1'b1;
            hits_exp = run;
            run = 0;
          end
        end
      end
      if (in_valid && in_ready) begin
        if (m_cnt == 0) begin m_dt = dt; m_wall = wall_en; end
        e.nhit = 0;
        for (int k = 0; k < 2; k++) begin
          model_lane(in_x[k*32 +: 32], in_y[k*32 +: 32], m_dt, m_wall, ox, oy, sat, hit);
          e.x[k*32 +: 32] = ox;
          e.y[k*32 +: 32] = oy;
          e.sat[k] = sat;
          e.nhit += int'(hit);
        end
        e.idx = 2'(m_cnt);
        e.last = (m_cnt == BEATS - 1);
        m_cnt = (m_cnt + 1) % BEATS;
        exp_q.push_back(e);
      end
    end
  end

  // Downstream ready: always, random, or forced low
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic [31:0] d, input logic w);
    bit acc;
    int n;
    n = 0;
    in_valid = 1'b1; in_x = x; in_y = y; dt = d; wall_en = w;
    do begin
      @(negedge clk); acc = in_ready;
      @(posedge clk); #1; n++;
    end while (!acc && n < 200);
    if (!acc) begin
      total++;
      $display("FAIL send_timeout: got no accept in %0d cycles expected accept", n);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 32'd393216)) - 32'd196608;
      2: return 32'($urandom_range(0, 32'd8)) << 14;
      default: return 32'd0 - (32'($urandom_range(0, 32'd8)) << 14);
    endcase
  endfunction

  function automatic logic [31:0] rnd_dt();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'($urandom_range(0, 32'd65536));
      2: return 32'h0000_8000;
      default: return 32'd0 - 32'($urandom_range(0, 32'd65536));
    endcase
  endfunction

  initial begin : main
    beat_t b;
    logic [31:0] ox, oy;
    logic sat, hit;
    longint t0;
    int n0;

    model_lane(32'h0000_4000, 32'h0002_0000, 32'h0000_8000, 1'b0, ox, oy, sat, hit);
    chk("model_pin_nowall", ox, 32'h0001_4000);
    model_lane(32'h0000_0000, 32'h0000_7FFF, 32'h0000_0001, 1'b0, ox, oy, sat, hit);
    chk("model_pin_round", ox, 32'h0000_0000);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_outputs", {out_x, out_y, out_idx, out_last, out_sat}, 133'd0);
    chk("rst_hits", {hits, hits_valid}, 5'd0);
    rst = 1'b0;
    idle(2);

    // Frame A: wall hits, exact -ONE, dt/wall_en changes after beat 0 ignored
    send({32'hFFFF_C000, 32'h0000_4000}, {32'hFFFE_0000, 32'h0002_0000}, 32'h0000_8000, 1'b1);
    send({32'h0000_4000, 32'hFFFF_8000}, {32'h0002_0000, 32'hFFFF_0000}, 32'h0000_0000, 1'b0);
    send(64'd0, 64'd0, 32'h0000_1234, 1'b0);
    send(64'd0, 64'd0, 32'h0000_0000, 1'b1);
    idle(4);

    // Frame B: wall off, two-cycle latency
    send({32'h0, 32'h0000_4000}, {32'h0, 32'h0002_0000}, 32'h0000_8000, 1'b0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_1", out_valid, 1'b0);
    @(negedge clk);
    chk("latency_2", out_valid, 1'b1);
    chk("latency_x", out_x[31:0], 32'h0001_4000);
    @(posedge clk); #1;
    repeat (3) send(64'd0, 64'd0, 32'h0, 1'b0);

    // Frame C: saturation; Frame D: rounding
    send({32'h0, 32'h7FFF_0000}, {32'h0, 32'h7FFF_0000}, 32'h0001_0000, 1'b0);
    repeat (3) send(64'd0, 64'd0, 32'h0, 1'b0);
    send(64'd0, {32'h0000_7FFF, 32'h0000_8000}, 32'h0000_0001, 1'b0);
    repeat (3) send(64'd0, 64'd0, 32'h0, 1'b0);
    idle(4);

    b = log_q[0];
    chk("wall_hit_x", b.x[31:0], 32'h0001_0000);
    chk("wall_hit_y", b.y[31:0], 32'h0);
    chk("neg_wall_x", b.x[63:32], 32'hFFFF_0000);
    chk("neg_wall_y", b.y[63:32], 32'h0);
    b = log_q[1];
    chk("exact_neg_one", {b.x[31:0], b.y[31:0]}, {32'hFFFF_0000, 32'hFFFF_0000});
    chk("latched_dt_wall", b.x[63:32], 32'h0001_0000);
    b = log_q[3];
    chk("last_beat", {b.idx, b.last}, 3'b111);
    chk("frame_hits", hits_log[0], 3);
    b = log_q[4];
    chk("nowall_xy", {b.x[31:0], b.y[31:0]}, {32'h0001_4000, 32'h0002_0000});
    b = log_q[8];
    chk("saturate", {b.x[31:0], b.sat}, {32'h7FFF_FFFF, 2'b01});
    b = log_q[12];
    chk("round_half_up", b.x, {32'h0, 32'h1});

    // Backpressure: out_ready low for 3 cycles mid-stream
    fork
      begin
        repeat (4) @(posedge clk);
        rdy_mode = 2;
        repeat (3) @(posedge clk);
        rdy_mode = 0;
      end
    join_none
    repeat (8) send({rnd_word(), rnd_word()}, {rnd_word(), rnd_word()}, rnd_dt(), 1'($urandom));
    idle(6);

    // Throughput: 8 beats in 8 cycles
    t0 = longint'($time);
    repeat (8) send({rnd_word(), rnd_word()}, {rnd_word(), rnd_word()}, rnd_dt(), 1'($urandom));
    chk("throughput", longint'($time) - t0, 64'd80);
    idle(4);

    // Reset after beat 2 of a frame
    repeat (3) send({32'h0, 32'h0000_4000}, {32'h0002_0000, 32'h0002_0000}, 32'h0000_8000, 1'b1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_outputs", {out_valid, out_x, out_y, out_idx, out_last, out_sat}, 134'd0);
    chk("midrst_hits", {hits, hits_valid}, 5'd0);
    rst = 1'b0;
    n0 = log_q.size();
    send({32'h0, 32'h0000_4000}, {32'h0, 32'h0002_0000}, 32'h0001_0000, 1'b0);
    repeat (3) send(64'd0, 64'd0, 32'h0000_8000, 1'b1);
    idle(4);
    b = log_q[n0];
    chk("post_rst_beat0", {b.idx, b.x[31:0]}, {2'd0, 32'h0002_4000});

    // Random traffic with random backpressure
    rdy_mode = 1;
    repeat (80) send({rnd_word(), rnd_word()}, {rnd_word(), rnd_word()}, rnd_dt(), 1'($urandom));
    rdy_mode = 0;
    idle(10);
    chk("drain", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
